// File: rtl/userio_debug.sv
// USERIO debug router: maps selectable debug sources onto USERIO pins as OFF/DIRECT/TOGGLE/STRETCH.
// Define USERIO_DEBUG_READBACK_EN to add registered MODE/SEL/STRETCH readback on reg_datao.
module userio_debug #(
  parameter int         pCHANNELS     = 8,
  parameter int         pINPUTS       = 16,
  parameter int         pBYTECNT_SIZE = 7,
  parameter logic [7:0] pADDR_BASE    = 8'd56
) (
  input  logic                     clk_usb,
  input  logic                     reset_i,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datai,
  output logic [7:0]               reg_datao,
  input  logic                     reg_read,
  input  logic                     reg_write,
  input  logic                     reg_addrvalid,
  input  logic [pINPUTS-1:0]       debug_i,
  output logic [pCHANNELS-1:0]     userio_o,
  output logic [pCHANNELS-1:0]     userio_oe
);
  localparam int SELW = (pINPUTS > 1) ? $clog2(pINPUTS) : 1;
  localparam int EXTW = 1 << SELW;

  localparam logic [7:0] ADDR_MODE    = pADDR_BASE;
  localparam logic [7:0] ADDR_SEL     = pADDR_BASE + 8'd1;
  localparam logic [7:0] ADDR_STRETCH = pADDR_BASE + 8'd2;

  localparam logic [1:0] M_OFF     = 2'd0;
  localparam logic [1:0] M_DIRECT  = 2'd1;
  localparam logic [1:0] M_TOGGLE  = 2'd2;
  localparam logic [1:0] M_STRETCH = 2'd3;

  logic                      wr_en;
  logic                      wr_mode;
  logic                      wr_sel;
  logic                      wr_stretch;
  logic [7:0]                stretch_q;
  logic [7:0]                stretch_d;
  logic [EXTW-1:0]           dbg_ext;
  logic [2*pCHANNELS-1:0]    mode_flat;
  logic [SELW*pCHANNELS-1:0] sel_flat;

  assign wr_en      = reg_write & reg_addrvalid;
  assign wr_mode    = wr_en && (reg_address == ADDR_MODE);
  assign wr_sel     = wr_en && (reg_address == ADDR_SEL);
  assign wr_stretch = wr_en && (reg_address == ADDR_STRETCH);

  // Select values past the last real input land on the zero padding.
  always_comb begin
    dbg_ext                = '0;
    dbg_ext[pINPUTS-1:0]   = debug_i;
  end

  assign stretch_d = wr_stretch ? reg_datai : stretch_q;

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_d;
    end
  end

  for (genvar gi = 0; gi < pCHANNELS; gi++) begin : g_ch
    logic [1:0]      mode_q;
    logic [1:0]      mode_d;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] sel_d;
    logic            s1_q;
    logic            s1_d;
    logic            s2_q;
    logic            s2_d;
    logic            out_q;
    logic            out_d;
    logic            oe_q;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    logic            mode_hit;
    logic            sel_hit;
    logic            rise;

    assign mode_hit = wr_mode && (reg_bytecnt == pBYTECNT_SIZE'(gi / 4));
    assign sel_hit  = wr_sel && (reg_bytecnt == pBYTECNT_SIZE'(gi));
    assign rise     = s1_q & ~s2_q;

    always_comb begin
      mode_d = mode_q;
      if (mode_hit) begin
        mode_d = reg_datai[2*(gi%4) +: 2];
      end
      sel_d = sel_hit ? reg_datai[SELW-1:0] : sel_q;
      s1_d  = sel_hit ? 1'b0 : dbg_ext[sel_q];
      s2_d  = sel_hit ? 1'b0 : s1_q;

      out_d = out_q;
      cnt_d = '0;
      // A mode change restarts the channel and swallows any rise on the same edge.
      if (mode_d != mode_q) begin
        out_d = 1'b0;
      end else begin
        case (mode_q)
          M_DIRECT: out_d = s1_q;
          M_TOGGLE: begin
            if (rise) begin
              out_d = ~out_q;
            end
          end
          M_STRETCH: begin
            if (rise) begin
              cnt_d = stretch_q;
              out_d = 1'b1;
            end else if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
              out_d = 1'b1;
            end else begin
              out_d = 1'b0;
            end
          end
          default: out_d = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
      if (reset_i) begin
        mode_q <= M_OFF;
        sel_q  <= '0;
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        out_q  <= 1'b0;
        oe_q   <= 1'b0;
        cnt_q  <= '0;
      end else begin
        mode_q <= mode_d;
        sel_q  <= sel_d;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        out_q  <= out_d;
        oe_q   <= (mode_d != M_OFF);
        cnt_q  <= cnt_d;
      end
    end

    assign userio_o[gi]                 = out_q;
    assign userio_oe[gi]                = oe_q;
    assign mode_flat[2*gi +: 2]         = mode_q;
    assign sel_flat[SELW*gi +: SELW]    = sel_q;
  end

`ifdef USERIO_DEBUG_READBACK_EN
  logic [7:0] rd_d;
  logic [7:0] rd_q;

  always_comb begin
    rd_d = '0;
    if (reg_read) begin
      if (reg_address == ADDR_MODE) begin
        for (int k = 0; k < pCHANNELS; k++) begin
          if (reg_bytecnt == pBYTECNT_SIZE'(k / 4)) begin
            rd_d[2*(k%4) +: 2] = mode_flat[2*k +: 2];
          end
        end
      end else if (reg_address == ADDR_SEL) begin
        for (int k = 0; k < pCHANNELS; k++) begin
          if (reg_bytecnt == pBYTECNT_SIZE'(k)) begin
            rd_d[SELW-1:0] = sel_flat[SELW*k +: SELW];
          end
        end
      end else if (reg_address == ADDR_STRETCH) begin
        rd_d = stretch_q;
      end
    end
  end

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign reg_datao = rd_q;
`else
  logic unused_rd_sink;
  assign unused_rd_sink = ^{reg_read, mode_flat, sel_flat};
  assign reg_datao      = 8'd0;
`endif

endmodule

// File: tb/tb_userio_debug.sv
// Randomized self-checking bench for userio_debug against an event-history reference model.
module tb_userio_debug;
  localparam int         NCH  = 8;
  localparam int         PIN  = 16;
  localparam int         BCW  = 7;
  localparam logic [7:0] BASE = 8'd56;
  localparam int         MAXT = 8192;

  logic            clk_usb = 1'b0;
  logic            reset_i = 1'b1;
  logic [7:0]      reg_address;
  logic [BCW-1:0]  reg_bytecnt;
  logic [7:0]      reg_datai;
  logic [7:0]      reg_datao;
  logic            reg_read;
  logic            reg_write;
  logic            reg_addrvalid;
  logic [PIN-1:0]  debug_i;
  logic [NCH-1:0]  userio_o;
  logic [NCH-1:0]  userio_oe;

  always #5 clk_usb = ~clk_usb;

  userio_debug #(
    .pCHANNELS    (NCH),
    .pINPUTS      (PIN),
    .pBYTECNT_SIZE(BCW),
    .pADDR_BASE   (BASE)
  ) dut (
    .clk_usb      (clk_usb),
    .reset_i      (reset_i),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .reg_datai    (reg_datai),
    .reg_datao    (reg_datao),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .reg_addrvalid(reg_addrvalid),
    .debug_i      (debug_i),
    .userio_o     (userio_o),
    .userio_oe    (userio_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel history of the sampled source, epoch of the last
  // mode change, and the STRETCH value in force at every edge.
  int         t;
  bit         smp [NCH][MAXT];
  logic [7:0] stv [MAXT];
  logic [1:0] mode_m [NCH];
  logic [3:0] sel_m [NCH];
  int         epoch [NCH];
  logic [7:0] stretch_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit rise_at(int c, int r);
    return smp[c][r-1] && !smp[c][r-2];
  endfunction

  function automatic bit exp_out(int c);
    int w;
    bit p;
    w = epoch[c];
    if (mode_m[c] == 2'd0 || t <= w) return 1'b0;
    if (mode_m[c] == 2'd1) return smp[c][t-1];
    if (mode_m[c] == 2'd2) begin
      p = 1'b0;
      for (int r = w + 1; r <= t; r++) if (rise_at(c, r)) p = ~p;
      return p;
    end
    for (int r = t; r > w; r--) begin
      if (rise_at(c, r)) return (t - r) <= int'(stv[r]);
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_read(logic [7:0] a, int bc);
    logic [7:0] v;
    v = 8'd0;
    if (a == BASE) begin
      for (int c = 0; c < NCH; c++) if (c / 4 == bc) v[2*(c%4) +: 2] = mode_m[c];
    end else if (a == BASE + 8'd1) begin
      if (bc < NCH) v = {4'd0, sel_m[bc]};
    end else if (a == BASE + 8'd2) begin
      v = stretch_m;
    end
    return v;
  endfunction

  task automatic model_reset();
    t++;
    for (int c = 0; c < NCH; c++) begin
      mode_m[c]    = 2'd0;
      sel_m[c]     = 4'd0;
      epoch[c]     = t;
      smp[c][t]    = 1'b0;
      smp[c][t-1]  = 1'b0;
    end
    stretch_m = 8'd0;
    stv[t]    = 8'd0;
  endtask

  // One clock edge: advance the model with the inputs currently driven, then compare.
  task automatic step();
    logic [7:0]     exp_rd;
    logic [NCH-1:0] exp_o;
    logic [NCH-1:0] exp_oe;
    logic [1:0]     nm;
    bit             wr;
    bit             hit;
    exp_rd = 8'd0;
`ifdef USERIO_DEBUG_READBACK_EN
    if (reg_read) exp_rd = model_read(reg_address, int'(reg_bytecnt));
`endif
    if (t >= MAXT - 2) begin
      $display("FAIL model_history: edge budget exhausted at %0d", t);
      $fatal(1, "history overflow");
    end
    wr = reg_write && reg_addrvalid;
    t++;
    stv[t] = stretch_m;
    for (int c = 0; c < NCH; c++) begin
      hit = wr && (reg_address == BASE + 8'd1) && (int'(reg_bytecnt) == c);
      smp[c][t] = hit ? 1'b0 : ((int'(sel_m[c]) < PIN) ? debug_i[sel_m[c]] : 1'b0);
      if (hit) sel_m[c] = reg_datai[3:0];
      if (wr && reg_address == BASE && int'(reg_bytecnt) == c / 4) begin
        nm = reg_datai[2*(c%4) +: 2];
        if (nm != mode_m[c]) begin
          mode_m[c] = nm;
          epoch[c]  = t;
        end
      end
    end
    if (wr && reg_address == BASE + 8'd2) stretch_m = reg_datai;
    @(posedge clk_usb);
    #1;
    for (int c = 0; c < NCH; c++) begin
      exp_o[c]  = exp_out(c);
      exp_oe[c] = (mode_m[c] != 2'd0);
    end
    check("userio_o", 32'(userio_o), 32'(exp_o));
    check("userio_oe", 32'(userio_oe), 32'(exp_oe));
    check("reg_datao", 32'(reg_datao), 32'(exp_rd));
  endtask

  task automatic wr(input logic [7:0] a, input int bc, input logic [7:0] d, input bit v);
    reg_address   = a;
    reg_bytecnt   = BCW'(bc);
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = v;
    step();
    $display("write addr=%0d byte=%0d data=0x%02h valid=%0b", a, bc, d, v);
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input int bc);
    reg_address = a;
    reg_bytecnt = BCW'(bc);
    reg_read    = 1'b1;
    step();
    $display("read  addr=%0d byte=%0d data=0x%02h", a, bc, reg_datao);
    reg_read = 1'b0;
  endtask

  task automatic do_reset();
    #3 reset_i = 1'b1;
    #1;
    check("async_rst_userio_o", 32'(userio_o), 32'd0);
    check("async_rst_userio_oe", 32'(userio_oe), 32'd0);
    check("async_rst_reg_datao", 32'(reg_datao), 32'd0);
    repeat (2) @(posedge clk_usb);
    #1 reset_i = 1'b0;
    model_reset();
    $display("reset pulse applied");
  endtask

  task automatic stretch_pulses(input int gap, output int hi);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      debug_i[7] = (i == 0) || (gap > 0 && i == gap);
      step();
      hi += int'(userio_o[2]);
    end
    $display("stretch pulse gap=%0d high_cycles=%0d", gap, hi);
  endtask

  initial begin
    bit   d_hist [16];
    int   hi;
    int   tg;
    logic prev;

    reg_address = 8'd0; reg_bytecnt = '0; reg_datai = 8'd0;
    reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0; debug_i = '0;
    t = 1;
    model_reset();
    #1;
    check("rst_userio_o", 32'(userio_o), 32'd0);
    check("rst_userio_oe", 32'(userio_oe), 32'd0);
    check("rst_reg_datao", 32'(reg_datao), 32'd0);
    repeat (2) @(posedge clk_usb);
    #1 reset_i = 1'b0;
    model_reset();
    step();

    wr(BASE, 0, 8'h55, 1'b1);
    check("oe_after_0x55", 32'(userio_oe[3:0]), 32'hF);

    // DIRECT ch0 from debug_i[3]: output repeats the source two edges later.
    wr(BASE + 8'd1, 0, 8'd3, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d_hist[i]  = (i % 4 < 2) ^ ($urandom_range(0, 3) == 0);
      debug_i[3] = d_hist[i];
      step();
      if (i >= 1) check("direct_latency", 32'(userio_o[0]), 32'(d_hist[i-1]));
    end
    $display("direct ch0 sel=3 run done");
    debug_i = '0;

    // ch0 DIRECT, ch1 TOGGLE (sel 5), ch2 STRETCH (sel 7), ch3 OFF.
    wr(BASE + 8'd1, 1, 8'd5, 1'b1);
    wr(BASE + 8'd1, 2, 8'd7, 1'b1);
    wr(BASE + 8'd2, 0, 8'd4, 1'b1);
    wr(BASE, 0, 8'h39, 1'b1);
    tg   = 0;
    prev = userio_o[1];
    for (int i = 0; i < 24; i++) begin
      debug_i[5] = (i % 3 == 0) && (i < 18);
      step();
      if (userio_o[1] !== prev) tg++;
      prev = userio_o[1];
    end
    $display("toggle ch1 transitions=%0d final=%0b", tg, userio_o[1]);
    check("toggle_transitions", 32'(tg), 32'd6);
    check("toggle_final", 32'(userio_o[1]), 32'd0);

    stretch_pulses(0, hi);
    check("stretch_single_high", 32'(hi), 32'd5);
    stretch_pulses(3, hi);
    check("stretch_retrig_high", 32'(hi), 32'd8);

    // Mode write lands on the same edge as a rise on ch2.
    debug_i[7] = 1'b1;
    step();
    wr(BASE, 0, 8'h29, 1'b1);
    check("modewr_rise_now", 32'(userio_o[2]), 32'd0);
    repeat (4) step();
    check("modewr_rise_after", 32'(userio_o[2]), 32'd0);
    debug_i[7] = 1'b0;
    repeat (2) step();

    // Reset while ch2 is mid-stretch.
    wr(BASE, 0, 8'h39, 1'b1);
    wr(BASE + 8'd2, 0, 8'd20, 1'b1);
    debug_i[7] = 1'b1;
    step();
    debug_i[7] = 1'b0;
    repeat (3) step();
    check("stretch_active_pre_rst", 32'(userio_o[2]), 32'd1);
    do_reset();
    repeat (3) step();
    check("post_rst_userio_o", 32'(userio_o), 32'd0);
    check("post_rst_userio_oe", 32'(userio_oe), 32'd0);

    wr(BASE + 8'd1, 2, 8'h0B, 1'b1);
    rd(BASE + 8'd1, 2);
`ifdef USERIO_DEBUG_READBACK_EN
    check("readback_sel2", 32'(reg_datao), 32'h0B);
`else
    check("readback_sel2", 32'(reg_datao), 32'h00);
`endif
    rd(8'h10, 0);
    check("readback_unmatched", 32'(reg_datao), 32'h00);
    step();

    for (int e = 0; e < 25; e++) begin
      for (int k = 0; k < $urandom_range(1, 3); k++) begin
        case ($urandom_range(0, 3))
          0: wr(BASE, $urandom_range(0, 2), 8'($urandom), $urandom_range(0, 7) != 0);
          1: wr(BASE + 8'd1, $urandom_range(0, 9), 8'($urandom), $urandom_range(0, 7) != 0);
          2: wr(BASE + 8'd2, 0, 8'($urandom_range(0, 6)), $urandom_range(0, 7) != 0);
          default: wr(BASE + 8'd3, 0, 8'($urandom), 1'b1);
        endcase
      end
      rd(8'(BASE + 8'($urandom_range(0, 3))), $urandom_range(0, 3));
      for (int i = 0; i < 40; i++) begin
        debug_i = debug_i ^ PIN'($urandom & $urandom);
        if ($urandom_range(0, 15) == 0) wr(BASE, $urandom_range(0, 1), 8'($urandom), 1'b1);
        else step();
      end
      if (e % 9 == 8) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/userio_debug.md
USERIO_DEBUG -- requirements
Module: userio_debug

Interface
REQ-001 Parameter pCHANNELS, default 8: number of USERIO output channels, range 1..16.
REQ-002 Parameter pINPUTS, default 16: number of selectable debug source signals, range 2..256.
REQ-003 Parameter pBYTECNT_SIZE, default 7: width of reg_bytecnt.
REQ-004 Parameter pADDR_BASE, default 8'd56: MODE register at pADDR_BASE, SEL at pADDR_BASE+1, STRETCH at pADDR_BASE+2.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 clk_usb  input  1  sole clock; all logic rising-edge.
REQ-007 reset_i  input  1  asynchronous, active-high reset.
REQ-008 reg_address  input  8  register address.
REQ-009 reg_bytecnt  input  pBYTECNT_SIZE  byte index within a multi-byte register.
REQ-010 reg_datai  input  8  write data.
REQ-011 reg_datao  output  8  read data; ORed onto the shared read bus.
REQ-012 reg_read, reg_write, reg_addrvalid  input  1 each  bus strobes.
REQ-013 debug_i  input  pINPUTS  debug sources, already in the clk_usb domain.
REQ-014 userio_o  output  pCHANNELS  USERIO drive values.
REQ-015 userio_oe  output  pCHANNELS  per-channel output enable; 0 means the top level tristates the pin.

Function
REQ-016 Each channel n SHALL hold mode[1:0]: 0=OFF, 1=DIRECT, 2=TOGGLE, 3=STRETCH.
REQ-017 MODE write: the byte at reg_bytecnt=k SHALL load channels 4k..4k+3, 2 bits each, LSB first; bytes beyond the channel count SHALL be ignored.
REQ-018 SEL write: the byte at reg_bytecnt=n SHALL set sel[n] = reg_datai[clog2(pINPUTS)-1:0]; a sel value >= pINPUTS SHALL source constant 0.
REQ-019 STRETCH write (8 bits) SHALL be global to all channels.
REQ-020 Writes SHALL take effect only when reg_write && reg_addrvalid; all writes complete in 1 cycle.
REQ-021 Pipeline: s1[n] <= debug_i[sel[n]]; s2[n] <= s1[n]; rise[n] = s1[n] & ~s2[n].
REQ-022 OFF SHALL give userio_oe[n]=0 and userio_o[n]=0.
REQ-023 DIRECT SHALL give userio_o[n] <= s1[n]: a 2-cycle latency from debug_i to userio_o.
REQ-024 TOGGLE SHALL invert userio_o[n] on each cycle where rise[n]=1, so the output runs at half the input event rate.
REQ-025 STRETCH: on rise[n], cnt[n] SHALL load STRETCH and userio_o[n] SHALL be 1 on the next edge.
REQ-026 STRETCH: while cnt[n]!=0, cnt[n] SHALL decrement and the output SHALL stay 1; output low only when cnt[n]==0 and no rise, giving a high time of STRETCH+1 cycles.
REQ-027 STRETCH retrigger: a rise while counting SHALL reload cnt[n] without dropping the output.
REQ-028 STRETCH=0 SHALL produce exactly a 1-cycle pulse per rise.
REQ-029 userio_oe[n] SHALL be registered and equal (mode[n]!=0).
REQ-030 A MODE write that changes mode[n] SHALL clear userio_o[n] and cnt[n] on the same edge; the write wins over a simultaneous rise.
REQ-031 A SEL write SHALL also clear s1[n] and s2[n], so a changed select produces no spurious edge.
REQ-032 reg_datao SHALL be 0 whenever the address does not match one of the block's registers.

Reset
REQ-033 Asserting reset_i SHALL asynchronously clear mode, sel, STRETCH, cnt, s1, s2, userio_o, userio_oe and reg_datao to 0.
REQ-034 Reset asserted mid-stretch or mid-toggle SHALL abort with outputs at 0; operation after release starts from the OFF state.

Configuration
REQ-035 Macro USERIO_DEBUG_READBACK_EN defined: reg_datao SHALL be registered, returning MODE/SEL/STRETCH bytes (indexed by reg_bytecnt) one cycle after the address and reg_read match, and 0 otherwise.
REQ-036 USERIO_DEBUG_READBACK_EN undefined: reg_datao SHALL be tied to constant 0 and no readback logic SHALL be synthesised.

Verification
REQ-037 Reset, then all outputs -> userio_o=0 and userio_oe=0; after MODE write 0x55 at byte 0 -> oe[3:0]=1111.
REQ-038 Ch0 DIRECT, sel=3, debug_i[3] toggles -> userio_o[0] follows exactly 2 cycles later.
REQ-039 Ch1 TOGGLE, 6 rising edges on the source -> userio_o[1] shows 3 full periods and ends at 0.
REQ-040 Ch2 STRETCH, STRETCH=4, single 1-cycle pulse -> high for 5 cycles; a second pulse at cycle 3 -> high for 5 cycles from the retrigger.
REQ-041 MODE write on the same cycle as a rise, and reset asserted mid-stretch -> output 0, no pulse.
REQ-042 Readback with the macro defined: write SEL byte 2 = 0x0B, read it back -> 0x0B (0 without the macro); reading an unmatched address -> 0.
